// File: rtl/redun_mont_sched.sv
// Iteration sequencer for the redundant-form Montgomery squarer: squares a seed T times and reports the result.
// Optional watchdog on the squarer response is compiled in with `define REDUN_MONT_SCHED_TIMEOUT_EN.
package redun_mont_sched_pkg;
  localparam int REDUN_W = 64;
  typedef logic [REDUN_W-1:0] redun0_t;
endpackage

module redun_mont_sched
  import redun_mont_sched_pkg::*;
#(
  parameter int CNT_W       = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  redun0_t          i_sq,
  input  logic [CNT_W-1:0] i_iter,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output redun0_t          o_result,
  output logic             o_err,
  output logic [CNT_W-1:0] o_iter_cnt,
  output redun0_t          o_mont_sq,
  output logic             o_mont_val,
  input  redun0_t          i_mont_mul,
  input  logic             i_mont_val,
  input  logic             i_mont_overflow
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] iter_t;
  logic [CNT_W-1:0] cnt_inc;

`ifdef REDUN_MONT_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  assign cnt_inc = o_iter_cnt + CNT_W'(1);

  // o_mont_sq doubles as the operand register: it only moves while o_mont_val is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      iter_t     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_result   <= '0;
      o_err      <= 1'b0;
      o_iter_cnt <= '0;
      o_mont_sq  <= '0;
      o_mont_val <= 1'b0;
`ifdef REDUN_MONT_SCHED_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      o_done     <= 1'b0;
      o_mont_val <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            o_mont_sq  <= i_sq;
            iter_t     <= i_iter;
            o_iter_cnt <= '0;
            o_err      <= 1'b0;
            o_busy     <= 1'b1;
            if (i_iter == '0) begin
              o_result <= i_sq;
              o_done   <= 1'b1;
              state    <= DONE;
            end else begin
              o_mont_val <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (i_abort) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
`ifdef REDUN_MONT_SCHED_TIMEOUT_EN
            wd_cnt <= '0;
`endif
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (i_abort) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else if (i_mont_val) begin
            o_mont_sq  <= i_mont_mul;
            o_iter_cnt <= cnt_inc;
            if (i_mont_overflow || (cnt_inc == iter_t)) begin
              o_err    <= i_mont_overflow;
              o_result <= i_mont_mul;
              o_done   <= 1'b1;
              state    <= DONE;
            end else begin
              o_mont_val <= 1'b1;
              state      <= ISSUE;
            end
          end
`ifdef REDUN_MONT_SCHED_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
            o_err    <= 1'b1;
            o_result <= o_mont_sq;
            o_done   <= 1'b1;
            state    <= DONE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_redun_mont_sched.sv
// Self-checking bench for redun_mont_sched: randomized runs against a schedule-level reference model.
`timescale 1ns/1ps
module tb_redun_mont_sched;
  import redun_mont_sched_pkg::*;

  localparam int CNT_W = 64;
`ifdef REDUN_MONT_SCHED_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif
  localparam longint unsigned MODN = 64'd65521;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic             i_abort = 1'b0;
  logic             i_mont_val = 1'b0;
  logic             i_mont_overflow = 1'b0;
  redun0_t          i_sq = '0;
  redun0_t          i_mont_mul = '0;
  logic [CNT_W-1:0] i_iter = '0;
  logic             o_busy, o_done, o_err, o_mont_val;
  redun0_t          o_result, o_mont_sq;
  logic [CNT_W-1:0] o_iter_cnt;

  redun_mont_sched #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_sq(i_sq), .i_iter(i_iter),
    .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_err(o_err),
    .o_iter_cnt(o_iter_cnt), .o_mont_sq(o_mont_sq), .o_mont_val(o_mont_val),
    .i_mont_mul(i_mont_mul), .i_mont_val(i_mont_val), .i_mont_overflow(i_mont_overflow)
  );

  always #5 i_clk = ~i_clk;

  int     n_tests = 0;
  int     n_fail = 0;
  longint cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic redun0_t sqf(input redun0_t x);
    longint unsigned r;
    r = x % MODN;
    return redun0_t'((r * r) % MODN);
  endfunction

  // Squarer model: fixed latency sq_L, optional overflow on the sq_ovf_at-th response of a run
  typedef struct {longint due; redun0_t val;} resp_t;
  resp_t  sq_q[$];
  int     sq_L = 3;
  bit     sq_mute = 1'b0;
  longint sq_ovf_at = 0;
  longint sq_resp = 0;

  always @(negedge i_clk) begin
    resp_t r;
    i_mont_val      = 1'b0;
    i_mont_mul      = {$urandom, $urandom};
    i_mont_overflow = 1'($urandom_range(0, 1));
    if (i_rst_n) begin
      if (sq_q.size() > 0 && sq_q[0].due == cyc) begin
        r = sq_q.pop_front();
        sq_resp++;
        i_mont_val      = 1'b1;
        i_mont_mul      = r.val;
        i_mont_overflow = (sq_resp == sq_ovf_at);
      end
      if (o_mont_val && !sq_mute) sq_q.push_back('{cyc + sq_L, sqf(o_mont_sq)});
    end
  end

  // Reference model of one run, as a schedule: issue k at 1+k(L+1), result k at (k+1)(L+1)
  bit      m_act = 1'b0;
  bit      m_err = 1'b0;
  longint  m_s = 0, m_L = 3, m_nres = 0, m_nissue = 0, m_done = 0, m_abort = 0;
  redun0_t m_v[$];
  redun0_t m_fin = '0;
  redun0_t m_hold = '0;

  longint  obs_done_rel, obs_dones, obs_pulses, obs_gap, obs_last;
  redun0_t obs_result;
  logic    obs_err;
  longint  obs_cnt;

  task automatic compare();
    longint  rel, endr, idx, m, cnt_e;
    bit      busy_e, done_e, val_e, fin;
    if (!m_act) begin
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_done", 64'(o_done), 64'd0);
      chk("rst_result", o_result, 64'd0);
      chk("rst_err", 64'(o_err), 64'd0);
      chk("rst_cnt", o_iter_cnt, 64'd0);
      chk("rst_mont_sq", o_mont_sq, 64'd0);
      chk("rst_mont_val", 64'(o_mont_val), 64'd0);
    end else begin
      rel    = cyc - m_s;
      endr   = (m_abort != 0) ? m_abort : m_done;
      busy_e = (rel >= 1) && (rel <= endr);
      done_e = (m_abort == 0) && (rel == m_done);
      fin    = (m_abort == 0) && (rel >= m_done);
      idx    = (rel - 1) / (m_L + 1);
      val_e  = busy_e && (((rel - 1) % (m_L + 1)) == 0) && (idx < m_nissue);
      m      = (m_abort != 0 && m_abort < rel) ? m_abort : rel;
      cnt_e  = (m - 1) / (m_L + 1);
      if (cnt_e > m_nres) cnt_e = m_nres;
      chk("busy", 64'(o_busy), 64'(busy_e));
      chk("done", 64'(o_done), 64'(done_e));
      chk("mont_val", 64'(o_mont_val), 64'(val_e));
      if (val_e) chk("mont_sq", o_mont_sq, m_v[idx]);
      chk("iter_cnt", o_iter_cnt, 64'(cnt_e));
      chk("err", 64'(o_err), fin ? 64'(m_err) : 64'd0);
      chk("result", o_result, fin ? m_fin : m_hold);
      if (o_done) begin
        obs_done_rel = rel; obs_dones++;
        obs_result = o_result; obs_err = o_err; obs_cnt = longint'(o_iter_cnt);
      end
      if (o_mont_val) begin
        if (obs_pulses > 0) obs_gap = rel - obs_last;
        obs_last = rel; obs_pulses++;
      end
    end
  endtask

  initial forever begin
    @(posedge i_clk);
    #1;
    compare();
  end

  task automatic run(input redun0_t seed, input logic [CNT_W-1:0] t, input longint ovf_at,
                     input longint abort_at, input bit mute, input longint rst_at);
    longint endr, tcap;
    @(negedge i_clk);
    m_hold = (m_act && m_abort == 0) ? m_fin : m_hold;
    m_L = sq_L;
    tcap = (t > 64'd10000) ? 10000 : longint'(t);
    m_v.delete();
    m_v.push_back(seed);
    if (t == '0) begin
      m_nissue = 0; m_nres = 0; m_err = 1'b0; m_done = 1;
    end else if (mute) begin
      m_nissue = 1; m_nres = 0; m_err = 1'b1; m_done = TO + 2;
    end else begin
      m_err    = (ovf_at > 0) && (ovf_at <= tcap);
      m_nres   = m_err ? ovf_at : tcap;
      m_nissue = m_nres;
      m_done   = m_nres * (m_L + 1) + 1;
    end
    for (longint i = 1; i <= m_nres && i <= 100; i++) m_v.push_back(sqf(m_v[i-1]));
    m_fin   = m_v[m_v.size()-1];
    m_abort = (abort_at >= 1 && abort_at <= m_done - 1) ? abort_at : 0;
    m_s = cyc; m_act = 1'b1;
    obs_done_rel = -1; obs_dones = 0; obs_pulses = 0; obs_gap = 0; obs_last = 0;
    sq_resp = 0; sq_ovf_at = ovf_at; sq_mute = mute;
    i_start = 1'b1; i_sq = seed; i_iter = t; i_abort = 1'b0;
    endr = (m_abort != 0) ? m_abort : m_done;
    for (longint rel = 1; rel <= endr + m_L + 3; rel++) begin
      @(negedge i_clk);
      i_start = (rel <= endr) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_sq    = {$urandom, $urandom};
      i_iter  = CNT_W'($urandom_range(0, 3));
      i_abort = (rel == abort_at) || (rel > endr && $urandom_range(0, 3) == 0);
      if (rel == rst_at) begin
        i_start = 1'b0; i_abort = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(o_busy), 64'd0);
        chk("async_rst_result", o_result, 64'd0);
        chk("async_rst_cnt", o_iter_cnt, 64'd0);
        chk("async_rst_mont_val", 64'(o_mont_val), 64'd0);
        m_act = 1'b0; m_hold = '0; m_fin = '0; m_abort = 0;
        sq_q.delete();
        repeat (2) @(negedge i_clk);
        sq_q.delete();
        i_rst_n = 1'b1;
        break;
      end
    end
    i_start = 1'b0;
    i_abort = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;

    sq_L = 3;
    run(64'd3, 64'd4, 0, 0, 1'b0, 0);
    chk("t1_done_cycle", 64'(obs_done_rel), 64'd17);
    chk("t1_result", obs_result, 64'd64945);
    chk("t1_cnt", 64'(obs_cnt), 64'd4);
    chk("t1_err", 64'(obs_err), 64'd0);
    chk("t1_pulses", 64'(obs_pulses), 64'd4);
    chk("t1_pulse_gap", 64'(obs_gap), 64'd4);

    run(64'h5A, 64'd0, 0, 0, 1'b0, 0);
    chk("t2_done_cycle", 64'(obs_done_rel), 64'd1);
    chk("t2_result", obs_result, 64'h5A);
    chk("t2_pulses", 64'(obs_pulses), 64'd0);

    run(64'd3, 64'd5, 2, 0, 1'b0, 0);
    chk("t3_err", 64'(obs_err), 64'd1);
    chk("t3_cnt", 64'(obs_cnt), 64'd2);
    chk("t3_result", obs_result, 64'd81);

    run(64'd11, 64'd10, 0, 11, 1'b0, 0);
    chk("t4_no_done", 64'(obs_dones), 64'd0);
    chk("t4_cnt_held", o_iter_cnt, 64'd2);
    chk("t4_result_held", o_result, 64'd81);
    run(64'd7, 64'd1, 0, 0, 1'b0, 0);
    chk("t4b_result", obs_result, 64'd49);

    run(64'd5, 64'd6, 0, 0, 1'b0, 10);
    run(64'd10, 64'd2, 0, 0, 1'b0, 0);
    chk("t5_result", obs_result, 64'd10000);
    chk("t5_cnt", 64'(obs_cnt), 64'd2);

    run({$urandom, $urandom}, '1, 0, 20, 1'b0, 0);
    run(64'd9, 64'd2, 0, 9, 1'b0, 0);

`ifdef REDUN_MONT_SCHED_TIMEOUT_EN
    run(64'd9, 64'd3, 0, 0, 1'b1, 0);
    chk("wd_done_cycle", 64'(obs_done_rel), 64'd18);
    chk("wd_err", 64'(obs_err), 64'd1);
    chk("wd_result", obs_result, 64'd9);
`endif

    for (int k = 0; k < 30; k++) begin
      longint t, ovf, ab;
      sq_L = $urandom_range(1, 4);
      t    = $urandom_range(0, 6);
      ovf  = ($urandom_range(0, 2) == 0) ? longint'($urandom_range(1, 7)) : 0;
      ab   = ($urandom_range(0, 2) == 0) ? longint'($urandom_range(1, 6 * (sq_L + 1) + 2)) : 0;
      run({$urandom, $urandom}, CNT_W'(t), ovf, ab, 1'b0, 0);
    end

    repeat (2) @(negedge i_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/redun_mont_sched.md
# redun_mont_sched

Iteration sequencer for the redundant-form Montgomery squarer (`redun_mont`) in the VDF datapath. It accepts a seed value and an iteration count T, repeatedly feeds each squarer output back as the next input until T squarings are done, then presents the final value with a one-cycle done pulse. It sits between the host/shell control logic and a single `redun_mont` instance and is the only driver of that instance's input handshake.

## Interface
- `CNT_W`, 64: width of the iteration count and progress counter.
- `TIMEOUT_CYC`, 1024: watchdog limit in cycles; used only when the watchdog is compiled in.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_sq`  in  redun0_t  seed value; captured with `i_start`.
- `i_iter`  in  CNT_W  number of squarings T; captured with `i_start`.
- `i_abort`  in  1  abandon the current run.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse when the result is valid.
- `o_result`  out  redun0_t  final value; held until the next `o_done`.
- `o_err`  out  1  run ended on overflow or timeout; valid with `o_done`, held until next start.
- `o_iter_cnt`  out  CNT_W  completed squarings in the current or last run.
- `o_mont_sq`  out  redun0_t  operand to the squarer.
- `o_mont_val`  out  1  operand valid; one-cycle pulse.
- `i_mont_mul`  in  redun0_t  squarer result.
- `i_mont_val`  in  1  result valid.
- `i_mont_overflow`  in  1  squarer overflow flag; qualified by `i_mont_val`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: on `i_start`, latch `i_sq` into the operand register, latch `i_iter`, clear `o_iter_cnt` and `o_err`. Go to DONE if T=0, else to ISSUE. While not in IDLE, `i_start` is ignored.
- ISSUE: drive `o_mont_val`=1 with `o_mont_sq` = operand register; go to WAIT.
- WAIT: on `i_mont_val`:
  - load `i_mont_mul` into the operand register;
  - increment `o_iter_cnt`;
  - if `i_mont_overflow`, set `o_err` and go to DONE;
  - else if new count == T, go to DONE;
  - else go to ISSUE.
- DONE: `o_done`=1 for exactly one cycle and `o_result` = operand register; return to IDLE.
- For T=0, `o_result` equals the seed.
- `i_abort` in ISSUE or WAIT: go to IDLE next cycle with no `o_done`. `o_result` and `o_err` are unchanged. A squarer result still in flight arrives in IDLE and is ignored. `i_abort` in IDLE or DONE has no effect. When abort and `i_mont_val` arrive together, abort wins.
- `i_mont_val` outside WAIT is ignored.
- Counter compare is an unsigned CNT_W-bit equality, so T = 2^CNT_W − 1 is legal. The counter never wraps.
- Reset values: `o_busy`=0, `o_done`=0, `o_result`=0, `o_err`=0, `o_iter_cnt`=0, `o_mont_sq`=0, `o_mont_val`=0, state=IDLE. Asserting reset mid-run drops the run immediately with no done pulse.

## Timing
- All outputs are registered. `o_mont_sq` is stable whenever `o_mont_val`=1.
- L = squarer latency, counted from the `o_mont_val` cycle to the `i_mont_val` cycle (L ≥ 1).
- Start sampled at cycle 0:
  - first ISSUE at cycle 1;
  - each iteration takes L+1 cycles;
  - `o_done` is high at cycle T·(L+1)+1;
  - for T=0, `o_done` is high at cycle 1.
- `o_busy` rises the cycle after start and falls the cycle after `o_done`. A new `i_start` is accepted on the cycle `o_busy` is low.

## Configuration
- `REDUN_MONT_SCHED_TIMEOUT_EN` defined:
  - a watchdog counts WAIT cycles and clears on entering WAIT;
  - reaching `TIMEOUT_CYC` sets `o_err` and goes to DONE;
  - `o_result` then holds the last operand issued.
- Not defined: no watchdog logic, and WAIT waits indefinitely.

## Test plan
- Model squarer with L=3 (x→x² mod small N), seed 3, T=4 → `o_done` at cycle 17, `o_iter_cnt`=4, `o_result`=3^16 mod N, `o_err`=0, exactly four `o_mont_val` pulses spaced 4 cycles apart.
- Seed 0x5A, T=0 → `o_done` at cycle 1, `o_result`=0x5A, no `o_mont_val` pulse.
- T=5, model asserts `i_mont_overflow` on the 2nd result → `o_done` with `o_err`=1, `o_iter_cnt`=2; `i_start` pulses while busy are ignored.
- T=10, `i_abort` in WAIT of iteration 3 → `o_busy` low next cycle, no `o_done`, late `i_mont_val` ignored; a following run with T=1 completes correctly.
- `i_rst_n` asserted mid-run, asynchronous to the clock edge → all outputs are 0 immediately; after release, a run with T=2 completes correctly.
- With `REDUN_MONT_SCHED_TIMEOUT_EN` and `TIMEOUT_CYC`=16, squarer never responds → `o_done` with `o_err`=1, 17 cycles after the ISSUE cycle.
